// File: rtl/nibble_serial_adder.sv
// Wide adder that walks WIDTH-bit operands through a 4-bit carry-skip slice,
// one nibble per clock, LSB first, with the carry chained through a register.
//   state  | meaning
//   IDLE   | ready for operands; last result still visible on o_sum/o_cout/o_ovf
//   RUN    | one nibble added per clock, r_idx selects the nibble
//   DONE   | result presented, waiting for the consumer handshake

module carryskipadder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_p    = a ^ b;
  assign w_c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_ripple
    assign sum[i]   = w_p[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_p[i] & w_c[i]);
  end

  // A fully propagating nibble passes cin straight through.
  assign cout = (&w_p) ? cin : w_c[4];
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf,
  output logic             o_busy
);
  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic [IDXW-1:0]  r_idx;

  logic [IDXW+1:0]  w_base;
  logic [3:0]       w_slice_sum;
  logic             w_slice_cout;
  logic             w_accept;
  logic             w_last;

  assign w_base   = {r_idx, 2'b00};
  assign w_accept = (r_state == S_IDLE) && i_in_valid;
  assign w_last   = (r_idx == IDXW'(NIB - 1));

  carryskipadder u_slice (
    .a    (r_a[w_base +: 4]),
    .b    (r_b[w_base +: 4]),
    .cin  (r_carry),
    .sum  (w_slice_sum),
    .cout (w_slice_cout)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    o_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_in_ready = 1'b1;
        if (i_in_valid) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        o_busy = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        o_out_valid = 1'b1;
        if (i_out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_a     <= i_a;
      r_b     <= i_b;
      r_carry <= i_cin;
      r_sum   <= '0;
      r_idx   <= '0;
    end else if (r_state == S_RUN) begin
      r_sum[w_base +: 4] <= w_slice_sum;
      r_carry            <= w_slice_cout;
      if (w_last) begin
        r_cout <= w_slice_cout;
        // Signed overflow: like-signed operands producing a result of the other sign.
        r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_slice_sum[3] != r_a[WIDTH-1]);
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign o_sum  = r_sum;
  assign o_cout = r_cout;
  assign o_ovf  = r_ovf;
endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
Wide-operand adder front end that reuses the team's 4-bit carry-skip adder slice (carryskipadder: a[3:0], b[3:0], cin -> sum[3:0], cout). It registers WIDTH-bit operands, feeds them through the slice one nibble per clock (LSB nibble first), and chains the carry through a register. The assembled result is presented on a valid/ready output. It sits directly upstream of the slice and owns all sequencing for it.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 8
NIB, WIDTH/4, derived local: number of nibble steps; not overridable

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset
in_valid  input  1  operand request valid
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry into nibble 0
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  registered result
cout  output  1  carry out of top nibble
ovf  output  1  two's-complement overflow of the WIDTH-bit add
busy  output  1  high in RUN

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset: state=IDLE; in_ready=1; out_valid=0; busy=0; sum=0; cout=0; ovf=0; internal operand registers, carry register and nibble counter cleared.
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch a, b and cin into carry_r, clear sum register, set idx=0, go to RUN. in_valid alone never changes sum/cout/ovf.
- RUN: in_ready=0, busy=1. Each cycle drive slice with a_r[4*idx+:4], b_r[4*idx+:4], carry_r; at clock edge write slice sum into sum[4*idx+:4] and slice cout into carry_r. idx increments by 1. On step idx==NIB-1, also capture cout=slice cout and ovf=(a_r[WIDTH-1]==b_r[WIDTH-1]) && (slice sum[3]!=a_r[WIDTH-1]), then go to DONE.
- DONE: out_valid=1, busy=0, in_ready=0. sum, cout, ovf held stable while out_valid&&!out_ready. On out_valid&&out_ready go to IDLE. sum/cout/ovf keep their values in IDLE until the next accept.
- Latency: accept edge = E; out_valid rises after edge E+NIB (16-bit: 4 clocks). Throughput: one operation per NIB+2 cycles with out_ready tied high.
- No overlap: a new request cannot be accepted in the cycle out_valid&&out_ready handshakes; earliest accept is the following IDLE cycle.
- Counter: width clog2(NIB); never wraps, because RUN exits at NIB-1.
- Width rules: sum is the modulo-2^WIDTH result; {cout,sum} = a+b+cin exactly.
- Reset mid-operation, in any state: immediate return to reset values; partial results are discarded and no out_valid is produced.
- Input changes on a/b/cin after accept have no effect on the operation in flight.

Test Plan:
- WIDTH=16: a=0x0002, b=0x0004, cin=0 accepted at edge E -> out_valid high after E+4; sum=0x0006, cout=0, ovf=0.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Carry must ripple through all 4 nibble steps.
- a=0x7FFF, b=0x0000, cin=1 -> sum=0x8000, cout=0, ovf=1. Also a=0xFFFE, b=0xFFFE, cin=1 -> sum=0xFFFD, cout=1, ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> sum, cout and ovf stay constant; in_ready=0 with in_valid=1 held, so no new accept. Raise out_ready -> one handshake, IDLE next cycle, second request then accepted.
- Reset mid-run: assert rst after 2 RUN steps of 0x1234+0x4321 -> outputs go to reset values asynchronously, in_ready=1, no out_valid. The next op 0x1234+0x4321, cin=0, yields sum=0x5555.
- Random: 500 back-to-back ops with random a/b/cin and random out_ready -> every {cout,sum} equals a+b+cin. ovf is checked against the signed-overflow model, and latency is checked as exactly NIB from accept.
